// File: rtl/comp_cal_pkg.sv
// -----------------------------------------------------------------------------
// comp_cal_pkg
// Shared types and helpers for the comparator offset-calibration sequencer.
//   state_t     : sequencer states
//   CODE_MIN/MAX: legal range of the signed trim code
//   clamp_code  : saturates a 4-bit signed code into CODE_MIN..CODE_MAX
//   code2therm  : signed code -> {CALP[3:0], CALN[3:0]} thermometer enables
// -----------------------------------------------------------------------------
package comp_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    EVAL,
    PRECH,
    DECIDE,
    FINISH
  } state_t;

  localparam logic signed [3:0] CODE_MIN = -4'sd4;
  localparam logic signed [3:0] CODE_MAX = 4'sd4;

  function automatic logic signed [3:0] clamp_code(input logic signed [3:0] c);
    if (c > CODE_MAX) return CODE_MAX;
    if (c < CODE_MIN) return CODE_MIN;
    return c;
  endfunction

  // Positive codes enable the lowest c CALP bits, negative codes the lowest
  // -c CALN bits, so the two halves are never active together.
  function automatic logic [7:0] code2therm(input logic signed [3:0] c);
    logic [3:0] p;
    logic [3:0] n;
    int         ci;
    p  = '0;
    n  = '0;
    ci = int'(c);
    for (int i = 0; i < 4; i++) begin
      if (ci > i)  p[i] = 1'b1;
      if (-ci > i) n[i] = 1'b1;
    end
    return {p, n};
  endfunction

endpackage

// File: rtl/comp_cal_acc.sv
// -----------------------------------------------------------------------------
// comp_cal_acc
// Accumulates comparator decisions for one calibration trial.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : clears P/N counts and the decision counter (start of trial)
//   meta_clr   : clears the tie counter (start of a calibration run)
//   sample     : take one decision from outp/outn this cycle
//   outp, outn : comparator outputs
//   d          : signed P - N for the current trial
//   all_done   : N_AVG decisions have been taken since clr
//   meta_cnt   : saturating count of tie/metastable decisions in the run
// -----------------------------------------------------------------------------
module comp_cal_acc #(
  parameter int N_AVG = 16,
  localparam int C_W  = $clog2(N_AVG) + 1,
  localparam int D_W  = C_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  meta_clr,
  input  logic                  sample,
  input  logic                  outp,
  input  logic                  outn,
  output logic signed [D_W-1:0] d,
  output logic                  all_done,
  output logic [7:0]            meta_cnt
);

  logic [C_W-1:0] p_cnt;
  logic [C_W-1:0] n_cnt;
  logic [C_W-1:0] dec_cnt;

  // Zero-extend before subtracting so a full-scale count stays positive.
  assign d        = signed'({1'b0, p_cnt}) - signed'({1'b0, n_cnt});
  assign all_done = (dec_cnt == C_W'(N_AVG));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_cnt    <= '0;
      n_cnt    <= '0;
      dec_cnt  <= '0;
      meta_cnt <= '0;
    end else begin
      if (clr) begin
        p_cnt   <= '0;
        n_cnt   <= '0;
        dec_cnt <= '0;
      end else if (sample) begin
        dec_cnt <= dec_cnt + C_W'(1);
        unique case ({outp, outn})
          2'b10:   p_cnt <= p_cnt + C_W'(1);
          2'b01:   n_cnt <= n_cnt + C_W'(1);
          default: if (meta_cnt != 8'hff) meta_cnt <= meta_cnt + 8'd1;
        endcase
      end
      if (meta_clr) meta_cnt <= '0;
    end
  end

endmodule

// File: rtl/comp_offset_cal.sv
// -----------------------------------------------------------------------------
// comp_offset_cal
// Foreground offset-calibration sequencer for the SAR ADC dynamic comparator.
// Shorts the comparator inputs, fires COMP_CLK N_AVG times per trial, and
// steps a signed thermometer trim code until the decisions balance.
//   clk, rst            : clock, asynchronous active-high reset
//   start / abort       : one-cycle pulses to begin / stop calibration
//   load_en, load_code  : load a (clamped) trim code while idle
//   outp, outn          : comparator decision
//   comp_clk            : registered comparator clock during calibration
//   cal_mode, cal_short : calibration clock select / input short
//   calp, caln          : thermometer capacitor enables from code
//   code                : current signed trim code (-4..+4)
//   busy, done, err     : status (done/err sticky until the next start)
//   meta_cnt            : tie decisions counted in the last run
// -----------------------------------------------------------------------------
module comp_offset_cal
  import comp_cal_pkg::*;
#(
  parameter int N_AVG      = 16,
  parameter int EVAL_CYC   = 2,
  parameter int RST_CYC    = 2,
  parameter int SETTLE_CYC = 8,
  parameter int HYS        = 1,
  parameter int MAX_ITER   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              load_en,
  input  logic [3:0]        load_code,
  input  logic              outp,
  input  logic              outn,
  output logic              comp_clk,
  output logic              cal_mode,
  output logic              cal_short,
  output logic [3:0]        calp,
  output logic [3:0]        caln,
  output logic signed [3:0] code,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        meta_cnt
);

  localparam int D_W     = $clog2(N_AVG) + 2;
  localparam int MAX_A   = (EVAL_CYC > RST_CYC) ? EVAL_CYC : RST_CYC;
  localparam int MAX_CYC = (SETTLE_CYC > MAX_A) ? SETTLE_CYC : MAX_A;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IT_W    = $clog2(MAX_ITER + 1);

  state_t             state;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [IT_W-1:0]    iter;
  logic               prev_valid;
  logic               prev_down;

  logic signed [D_W-1:0] acc_d;
  logic                  acc_all_done;
  logic                  acc_clr;
  logic                  acc_sample;
  logic                  meta_clr;

  logic                  converged;
  logic                  step_down;
  logic                  at_limit;
  logic                  dither;
  logic signed [3:0]     step_code;
  logic [IT_W-1:0]       iter_next;
  int                    d_i;

  // P/N counts are cleared throughout SETTLE; the decision is taken on the
  // last high cycle of each COMP_CLK pulse.
  assign acc_clr    = (state == SETTLE);
  assign acc_sample = (state == EVAL) && (cyc_cnt == CNT_W'(EVAL_CYC - 1));
  assign meta_clr   = (state == IDLE) && start;

  comp_cal_acc #(.N_AVG(N_AVG)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .meta_clr (meta_clr),
    .sample   (acc_sample),
    .outp     (outp),
    .outn     (outn),
    .d        (acc_d),
    .all_done (acc_all_done),
    .meta_cnt (meta_cnt)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    d_i       = int'(acc_d);
    converged = (d_i <= HYS) && (d_i >= -HYS);
    step_down = (d_i > HYS);   // more P decisions -> lower the code
    at_limit  = step_down ? (code == CODE_MIN) : (code == CODE_MAX);
    step_code = step_down ? code - 4'sd1 : code + 4'sd1;
    // A reversal means the previous step overshot; stepping back lands on
    // the code held before that step.
    dither    = prev_valid && (prev_down != step_down);
    iter_next = iter + IT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      iter       <= '0;
      prev_valid <= 1'b0;
      prev_down  <= 1'b0;
      code       <= '0;
      comp_clk   <= 1'b0;
      cal_mode   <= 1'b0;
      cal_short  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_en) code <= clamp_code(signed'(load_code));
          if (start) begin
            done       <= 1'b0;
            err        <= 1'b0;
            iter       <= '0;
            prev_valid <= 1'b0;
            cyc_cnt    <= '0;
            busy       <= 1'b1;
            cal_mode   <= 1'b1;
            cal_short  <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (cyc_cnt == CNT_W'(SETTLE_CYC - 1)) begin
            cyc_cnt  <= '0;
            comp_clk <= 1'b1;
            state    <= EVAL;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end

        EVAL: begin
          if (cyc_cnt == CNT_W'(EVAL_CYC - 1)) begin
            cyc_cnt  <= '0;
            comp_clk <= 1'b0;
            state    <= PRECH;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end

        PRECH: begin
          if (cyc_cnt == CNT_W'(RST_CYC - 1)) begin
            cyc_cnt <= '0;
            if (acc_all_done) begin
              state <= DECIDE;
            end else begin
              comp_clk <= 1'b1;
              state    <= EVAL;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end

        DECIDE: begin
          iter <= iter_next;
          if (converged) begin
            done  <= 1'b1;
            state <= FINISH;
          end else if (dither) begin
            code  <= step_code;
            done  <= 1'b1;
            state <= FINISH;
          end else if (at_limit) begin
            err   <= 1'b1;
            state <= FINISH;
          end else begin
            code       <= step_code;
            prev_valid <= 1'b1;
            prev_down  <= step_down;
            if (iter_next == IT_W'(MAX_ITER)) begin
              err   <= 1'b1;
              state <= FINISH;
            end else begin
              state <= SETTLE;
            end
          end
        end

        FINISH: begin
          busy      <= 1'b0;
          cal_mode  <= 1'b0;
          cal_short <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Abort comes last so its assignments win over anything above,
      // including a code step from DECIDE in the same cycle.
      if (abort && (state != IDLE)) begin
        code      <= code;
        comp_clk  <= 1'b0;
        cal_mode  <= 1'b0;
        cal_short <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
        err       <= 1'b0;
        cyc_cnt   <= '0;
        state     <= IDLE;
      end
    end
  end

  // Enables follow the code one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calp <= '0;
      caln <= '0;
    end else begin
      {calp, caln} <= code2therm(code);
    end
  end

endmodule

// File: tb/tb_comp_offset_cal.sv
// -----------------------------------------------------------------------------
// tb_comp_offset_cal
// Drives comp_offset_cal with a deterministic comparator model
// (OUTP when 2*OFS + 2*CODE > 0, OUTN when < 0, tie at 0) and compares the
// end of every run against a trial-level reference of the calibration rules.
// -----------------------------------------------------------------------------
module tb_comp_offset_cal;

  localparam int N_AVG      = 16;
  localparam int EVAL_CYC   = 2;
  localparam int RST_CYC    = 2;
  localparam int SETTLE_CYC = 8;
  localparam int HYS        = 1;
  localparam int MAX_ITER   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              load_en = 1'b0;
  logic [3:0]        load_code = 4'd0;
  logic              outp;
  logic              outn;
  logic              comp_clk;
  logic              cal_mode;
  logic              cal_short;
  logic [3:0]        calp;
  logic [3:0]        caln;
  logic signed [3:0] code;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        meta_cnt;

  int vec_cnt  = 0;
  int miscmp   = 0;
  int ofs2_m   = 0;   // comparator offset in half-LSB units
  bit tie_m    = 1'b0;
  int cur_code = 0;   // bench's own view of the trim code
  int mx;

  typedef struct {
    int code;
    bit done;
    bit err;
    int meta;
    int trials;
  } result_t;

  comp_offset_cal #(
    .N_AVG(N_AVG), .EVAL_CYC(EVAL_CYC), .RST_CYC(RST_CYC),
    .SETTLE_CYC(SETTLE_CYC), .HYS(HYS), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .load_en   (load_en),
    .load_code (load_code),
    .outp      (outp),
    .outn      (outn),
    .comp_clk  (comp_clk),
    .cal_mode  (cal_mode),
    .cal_short (cal_short),
    .calp      (calp),
    .caln      (caln),
    .code      (code),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .meta_cnt  (meta_cnt)
  );

  always #5 clk = ~clk;

  // Comparator with shorted inputs: residual offset plus trim.
  always_comb begin
    mx = ofs2_m + 2 * int'(code);
    if (tie_m) begin
      outp = 1'b0;
      outn = 1'b0;
    end else begin
      outp = (mx > 0);
      outn = (mx < 0);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sext4(input int raw);
    int r;
    r = raw & 15;
    return (r > 7) ? r - 16 : r;
  endfunction

  function automatic int clampc(input int c);
    return (c > 4) ? 4 : ((c < -4) ? -4 : c);
  endfunction

  function automatic int therm_p(input int c);
    return (c > 0) ? (1 << c) - 1 : 0;
  endfunction

  function automatic int therm_n(input int c);
    return (c < 0) ? (1 << (-c)) - 1 : 0;
  endfunction

  // Trial-by-trial outcome of a calibration run.
  function automatic result_t ref_cal(input int start_code, input int ofs2, input bit tie);
    result_t r;
    int c;
    int prev;
    int x;
    int d;
    int dir;
    r    = '{code: 0, done: 1'b0, err: 1'b0, meta: 0, trials: 0};
    c    = start_code;
    prev = 0;
    for (int it = 1; it <= MAX_ITER; it++) begin
      r.trials = it;
      x = tie ? 0 : ofs2 + 2 * c;
      d = (x > 0) ? N_AVG : ((x < 0) ? -N_AVG : 0);
      if (x == 0) r.meta = (r.meta + N_AVG > 255) ? 255 : r.meta + N_AVG;
      if (d <= HYS && d >= -HYS) begin r.done = 1'b1; break; end
      dir = (d > HYS) ? -1 : 1;
      if (prev != 0 && dir != prev) begin c += dir; r.done = 1'b1; break; end
      if (c + dir > 4 || c + dir < -4) begin r.err = 1'b1; break; end
      c += dir;
      prev = dir;
      if (it == MAX_ITER) begin r.err = 1'b1; break; end
    end
    r.code = c;
    return r;
  endfunction

  // One full calibration run; called right after a falling edge.
  task automatic run_cal(input string tag, input int ofs2, input bit tie,
                         input bit ld, input int ld_raw, input bit same,
                         input bit busy_load);
    result_t r;
    int  start_code;
    int  pulses;
    int  viol;
    int  run_len;
    bit  prev_cc;
    bit  seen;
    bit  finished;
    logic [3:0] raw4;
    ofs2_m     = ofs2;
    tie_m      = tie;
    raw4       = 4'(ld_raw);
    start_code = ld ? clampc(sext4(ld_raw)) : cur_code;
    if (ld && !same) begin
      load_code = raw4;
      load_en   = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
    end
    start = 1'b1;
    if (ld && same) begin
      load_code = raw4;
      load_en   = 1'b1;
    end
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_short"}, cal_short, 1);
    if (busy_load) begin
      load_code = 4'b1101;
      load_en   = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      check({tag, "_busyload"}, code, start_code);
    end
    r        = ref_cal(start_code, ofs2, tie);
    pulses   = 0;
    viol     = 0;
    run_len  = 0;
    prev_cc  = 1'b0;
    seen     = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin finished = 1'b1; break; end
      if (comp_clk !== prev_cc) begin
        if (prev_cc) begin
          if (run_len != EVAL_CYC) viol++;
        end else if (seen && run_len != RST_CYC && run_len != RST_CYC + 1 + SETTLE_CYC) begin
          viol++;
        end
        if (comp_clk) begin pulses++; seen = 1'b1; end
        prev_cc = comp_clk;
        run_len = 1;
      end else begin
        run_len++;
      end
      @(negedge clk);
    end
    check({tag, "_finished"}, finished, 1);
    check({tag, "_code"}, code, r.code);
    check({tag, "_done"}, done, r.done);
    check({tag, "_err"}, err, r.err);
    check({tag, "_meta"}, meta_cnt, r.meta);
    check({tag, "_calp"}, calp, therm_p(r.code));
    check({tag, "_caln"}, caln, therm_n(r.code));
    check({tag, "_pulses"}, pulses, r.trials * N_AVG);
    check({tag, "_widths"}, viol, 0);
    check({tag, "_mode"}, {cal_mode, cal_short, comp_clk}, 0);
    cur_code = r.code;
  endtask

  initial begin
    int hi_cnt;
    bit hit;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_code", code, 0);
    check("rst_therm", {calp, caln}, 0);
    check("rst_ctl", {comp_clk, cal_mode, cal_short, busy}, 0);
    check("rst_flags", {done, err}, 0);
    check("rst_meta", meta_cnt, 0);

    // OFS = +2.5: 0 -> -1 -> -2 -> -3, reversal at -3 returns to -2.
    run_cal("ofs2p5", 5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("ofs2p5_const_code", code, -2);
    check("ofs2p5_const_caln", caln, 4'b0011);

    // Abort on the third high COMP_CLK cycle.
    ofs2_m = 5;
    tie_m  = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    hi_cnt = 0;
    hit    = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (comp_clk) hi_cnt++;
      if (hi_cnt == 3) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach", hit, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ctl", {comp_clk, cal_short, cal_mode, busy}, 0);
    check("abort_code", code, cur_code);
    check("abort_flags", {done, err}, 0);

    // OFS = +9: saturates at -4.
    run_cal("ofs9", 18, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("ofs9_const_caln", caln, 4'b1111);

    // Comparator never resolves: converges on ties in one trial.
    run_cal("ties", 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("ties_const_meta", meta_cnt, 16);

    // Load 0110 while idle clamps to +4.
    load_code = 4'b0110;
    load_en   = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check("load_code", code, 4);
    @(negedge clk);
    check("load_therm", {calp, caln}, 8'b1111_0000);
    cur_code = 4;

    // Load during a run is ignored.
    run_cal("busyld", -5, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Load and start together: run starts from clamped -7 -> -4.
    run_cal("ldstart", 7, 1'b0, 1'b1, 9, 1'b1, 1'b0);

    // Asynchronous reset with COMP_CLK high.
    load_code = 4'd3;
    load_en   = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    ofs2_m  = -5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (comp_clk) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("rstmid_reach", hit, 1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_ctl", {comp_clk, cal_mode, cal_short, busy}, 0);
    check("rstmid_code", code, 0);
    check("rstmid_therm", {calp, caln}, 0);
    @(negedge clk);
    rst      = 1'b0;
    cur_code = 0;
    @(negedge clk);
    run_cal("postrst", 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Randomized runs.
    for (int k = 0; k < 10; k++) begin
      run_cal($sformatf("rnd%0d", k), int'($urandom_range(0, 24)) - 12,
              ($urandom_range(0, 7) == 0), 1'b1, int'($urandom_range(0, 15)),
              bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/comp_offset_cal.md
Name: comp_offset_cal

Overview:
- Foreground offset-calibration sequencer for the dynamic comparator in the 10b SAR ADC.
- While calibration runs, the block:
  - shorts the comparator inputs through CAL_SHORT;
  - fires the comparator clock N_AVG times per trial;
  - counts OUTP/OUTN decisions;
  - steps a signed thermometer trim code that drives the CALP0..3 / CALN0..3 capacitor-enable bits.
- The final code is held for normal SAR conversions, and firmware can reload it.

Parameters:
- N_AVG, 16: comparator decisions per trial. Power of 2, range 2..256.
- EVAL_CYC, 2: cycles COMP_CLK stays high per decision. Minimum 1.
- RST_CYC, 2: cycles COMP_CLK stays low (precharge) between decisions. Minimum 1.
- SETTLE_CYC, 8: cycles waited after a code change or short assertion before the first decision.
- HYS, 1: dead band on (P-N) for declaring convergence.
- MAX_ITER, 16: trial limit before ERR is flagged.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse; begins calibration from the current code.
- ABORT  in  1  one-cycle pulse; stops calibration.
- LOAD_EN  in  1  loads LOAD_CODE into the trim code while idle.
- LOAD_CODE  in  4  signed trim code to load.
- OUTP  in  1  comparator positive output.
- OUTN  in  1  comparator negative output.
- COMP_CLK  out  1  comparator clock during calibration. Registered.
- CAL_MODE  out  1  high while calibrating; selects COMP_CLK over the SAR clock externally.
- CAL_SHORT  out  1  shorts VIP to VIN (common-mode) during calibration.
- CALP  out  4  CALP3..0 enables.
- CALN  out  4  CALN3..0 enables.
- CODE  out  4  current signed trim code, range -4..+4.
- BUSY  out  1  calibration in progress.
- DONE  out  1  sticky; last run converged.
- ERR  out  1  sticky; last run saturated or hit MAX_ITER.
- META_CNT  out  8  saturating count of tie/metastable decisions in the last run.

Behaviour:
- Reset values:
  - CODE=0, CALP=CALN=0.
  - COMP_CLK, CAL_MODE, CAL_SHORT, BUSY, DONE, ERR = 0.
  - META_CNT=0, state IDLE.
- Code mapping (registered, updates the cycle after CODE changes):
  - c>0: CALP[i]=1 for i<c.
  - c<0: CALN[i]=1 for i<-c.
  - c=0: all enables 0.
  - CALP and CALN are never both non-zero.
- IDLE:
  - LOAD_EN: CODE <= LOAD_CODE clamped to -4..+4 (e.g. 6 becomes 4, -7 becomes -4).
  - START: clear DONE, ERR, META_CNT and the iteration counter; set BUSY, CAL_MODE, CAL_SHORT; go to SETTLE.
  - START and LOAD_EN in the same cycle: the load applies first, then calibration starts from the loaded code.
- SETTLE: COMP_CLK=0 for SETTLE_CYC cycles, clear P/N counters, then go to EVAL.
- EVAL:
  - COMP_CLK=1 for EVAL_CYC cycles.
  - On the last high cycle, sample OUTP/OUTN:
    - OUTP=1, OUTN=0: P++.
    - OUTP=0, OUTN=1: N++.
    - Otherwise: tie, META_CNT++ (saturates at 255).
  - Then go to PRECH.
- PRECH: COMP_CLK=0 for RST_CYC cycles. If N_AVG decisions are done, go to DECIDE; else go to EVAL.
- DECIDE (1 cycle), with d = P - N (signed, width log2(N_AVG)+2) and iteration count incremented:
  - |d| <= HYS: converged. DONE=1, go to FINISH.
  - d > HYS, direction -1:
    - CODE == -4: ERR=1, go to FINISH.
    - Otherwise: CODE--.
  - d < -HYS, direction +1:
    - CODE == +4: ERR=1, go to FINISH.
    - Otherwise: CODE++.
  - Dither: if the direction is opposite to the previous trial's direction, undo the step (keep the prior code), DONE=1, go to FINISH.
  - Iteration count == MAX_ITER without converging: ERR=1, go to FINISH.
  - Otherwise: go to SETTLE.
- FINISH (1 cycle): drop CAL_SHORT, CAL_MODE and BUSY; go to IDLE.
- START while BUSY is ignored.
- ABORT in any busy state:
  - Next cycle: COMP_CLK=0, CAL_SHORT=0, CAL_MODE=0, BUSY=0.
  - CODE is kept at its current value; DONE=0, ERR=0; go to IDLE.
  - ABORT has priority over DECIDE results in the same cycle.
- RST at any time: immediate return to reset values, including mid-EVAL with COMP_CLK high.
- COMP_CLK is driven only from a flop, so it never glitches.

Decomposition:
- Package comp_cal_pkg holds:
  - the state enum (IDLE, SETTLE, EVAL, PRECH, DECIDE, FINISH);
  - CODE_MIN=-4 and CODE_MAX=4;
  - the function code2therm(signed code) returning {CALP, CALN}.
- One sub-module, comp_cal_acc: the P/N/tie accumulator with the decision counter and the done flag.

Test Plan:
- Behavioural comparator model OUTP = (OFS + CODE + noise > 0). OFS=+2.5, no noise, START → CODE steps 0→-1→-2→-3. The 0→-1→-2 steps each see d=+16; at -3 d=-16 reverses direction (dither), so the -3 step is undone. Result: DONE=1, CODE=-2, CALN=0011, CALP=0000.
- OFS=+9 → CODE saturates at -4, ERR=1, DONE=0, BUSY drops, CALN=1111.
- Model always returns OUTP=OUTN=0 → every trial d=0, converges in one trial: DONE=1, CODE unchanged, META_CNT=16.
- LOAD_EN with LOAD_CODE=4'b0110 while IDLE → CODE=4, CALP=1111. LOAD_EN while BUSY → CODE unchanged.
- ABORT on the 3rd EVAL cycle → next cycle COMP_CLK=0, CAL_SHORT=0, BUSY=0, CODE retained, DONE=ERR=0.
- RST asserted mid-EVAL → all outputs at reset values asynchronously; START after release runs normally. Also check COMP_CLK high/low widths equal EVAL_CYC/RST_CYC and exactly N_AVG pulses per trial.
